cpu_int_sequencer: RTL and testbench

- Parametrised interrupt, reset and BRK sequencer for the 2A03 core.
- Arbitrates reset, NMI, BRK and N maskable IRQ lines.
- While a sequence runs it takes over the address and data bus, runs the 7-cycle 6502 push/vector sequence, then hands the core a new PC and SP and a set-I pulse.
- It generalises the core's single nirq pin to NUM_IRQ prioritised lines, each with its own vector, and adds NMI hijack behaviour.

---
 rtl/cpu_int_sequencer_pkg.sv | 42 ++++
 rtl/cpu_int_sequencer_if.sv | 43 ++++
 rtl/cpu_int_sequencer_int_priority_enc.sv | 48 ++++
 rtl/cpu_int_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_cpu_int_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_int_sequencer_pkg.sv
// cpu_int_sequencer_pkg
// Shared definitions for the interrupt/reset/BRK sequencer: sequencer state
// encoding, taken-source codes, default vector addresses and the stack page
// helper used when forming push addresses.
package cpu_int_sequencer_pkg;

   // One state per bus cycle of the 7-cycle push/vector sequence
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_C1,
      ST_C2,
      ST_C3,
      ST_C4,
      ST_C5,
      ST_C6,
      ST_C7
   } seq_state_t;

   // Taken-source codes reported on src_id; IRQ line k reports SRC_IRQ0 + k
   localparam logic [3:0] SRC_RST  = 4'd0;
   localparam logic [3:0] SRC_NMI  = 4'd1;
   localparam logic [3:0] SRC_BRK  = 4'd2;
   localparam logic [3:0] SRC_IRQ0 = 4'd3;

   // Default vector low-byte addresses
   localparam logic [15:0] DEF_NMI_VEC      = 16'hFFFA;
   localparam logic [15:0] DEF_RST_VEC      = 16'hFFFC;
   localparam logic [15:0] DEF_IRQ_VEC      = 16'hFFFE;
   localparam logic [15:0] DEF_EXT_VEC_BASE = 16'hFFE0;

   // Status register bits forced into the pushed P byte
   localparam logic [7:0] P_UNUSED_BIT = 8'h20;
   localparam logic [7:0] P_BREAK_BIT  = 8'h10;

   localparam logic [7:0] STACK_PAGE = 8'h01;

   // The stack lives in page 1; the pointer wraps within the page
   function automatic logic [15:0] stack_addr(input logic [7:0] sp);
      return {STACK_PAGE, sp};
   endfunction

endpackage

// File: rtl/cpu_int_sequencer_if.sv
// cpu_int_sequencer_if
// Bundles the sequencer's bus and core-handoff signals.
//   bus side : busy, addr, data_out, rw (sequencer drives), data_in (memory drives)
//   core side: boundary, brk_req, i_flag, pc_in, sp_in, flags_in (core drives);
//              pc_load, pc_out, sp_load, sp_out, set_i, src_id (sequencer drives)
// modport master is the sequencer, modport slave is the core/memory side.
interface cpu_int_sequencer_if;

   logic        busy;
   logic [15:0] addr;
   logic [7:0]  data_out;
   logic        rw;
   logic [7:0]  data_in;

   logic        boundary;
   logic        brk_req;
   logic        i_flag;
   logic [15:0] pc_in;
   logic [7:0]  sp_in;
   logic [7:0]  flags_in;

   logic        pc_load;
   logic [15:0] pc_out;
   logic        sp_load;
   logic [7:0]  sp_out;
   logic        set_i;
   logic [3:0]  src_id;

   modport master (
      output busy, addr, data_out, rw,
      output pc_load, pc_out, sp_load, sp_out, set_i, src_id,
      input  data_in,
      input  boundary, brk_req, i_flag, pc_in, sp_in, flags_in
   );

   modport slave (
      input  busy, addr, data_out, rw,
      input  pc_load, pc_out, sp_load, sp_out, set_i, src_id,
      output data_in,
      output boundary, brk_req, i_flag, pc_in, sp_in, flags_in
   );

endinterface

// File: rtl/cpu_int_sequencer_int_priority_enc.sv
// int_priority_enc
// Combinational request arbiter: NMI > BRK > IRQ k (lowest k first).
// Ports:
//   enable   in  arbitration allowed this cycle (idle and at a boundary)
//   nmi_pend in  latched NMI edge
//   brk_req  in  core decoded a BRK
//   i_flag   in  interrupt-disable flag, masks all IRQ lines
//   nirq     in  active-low level IRQ lines
//   valid    out a request wins
//   src_id   out code of the winning source
module int_priority_enc
   import cpu_int_sequencer_pkg::*;
#(
   parameter int NUM_IRQ = 2
) (
   input  logic               enable,
   input  logic               nmi_pend,
   input  logic               brk_req,
   input  logic               i_flag,
   input  logic [NUM_IRQ-1:0] nirq,
   output logic               valid,
   output logic [3:0]         src_id
);

   // IRQ lines are scanned from the top down so the lowest asserted line
   // is the one left standing.
   always_comb begin
      valid  = 1'b0;
      src_id = SRC_RST;
      if (enable) begin
         if (nmi_pend) begin
            valid  = 1'b1;
            src_id = SRC_NMI;
         end else if (brk_req) begin
            valid  = 1'b1;
            src_id = SRC_BRK;
         end else if (!i_flag) begin
            for (int k = NUM_IRQ - 1; k >= 0; k--) begin
               if (!nirq[k]) begin
                  valid  = 1'b1;
                  src_id = SRC_IRQ0 + 4'(k);
               end
            end
         end
      end
   end

endmodule

// File: rtl/cpu_int_sequencer.sv
// cpu_int_sequencer
// Reset / NMI / BRK / IRQ sequencer for the 2A03 core. When a source is
// accepted it owns the bus for the 7-cycle 6502 push/vector sequence, then
// pulses pc_load/sp_load/set_i with the vector target and the new SP.
// Ports:
//   clock   in  system clock
//   nreset  in  synchronous active-high reset
//   nnmi    in  active-low NMI, falling-edge triggered
//   nirq    in  NUM_IRQ active-low level IRQ lines
//   bus     master modport: bus cycle outputs, core inputs, handoff pulses
module cpu_int_sequencer
   import cpu_int_sequencer_pkg::*;
#(
   parameter int          NUM_IRQ      = 2,
   parameter logic [15:0] NMI_VEC      = DEF_NMI_VEC,
   parameter logic [15:0] RST_VEC      = DEF_RST_VEC,
   parameter logic [15:0] IRQ_VEC      = DEF_IRQ_VEC,
   parameter logic [15:0] EXT_VEC_BASE = DEF_EXT_VEC_BASE
) (
   input  logic               clock,
   input  logic               nreset,
   input  logic               nnmi,
   input  logic [NUM_IRQ-1:0] nirq,
   cpu_int_sequencer_if.master bus
);

   seq_state_t  state_q, state_d;

   logic        busy_q, busy_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  data_out_q, data_out_d;
   logic        rw_q, rw_d;
   logic        pulse_q, pulse_d;
   logic [15:0] pc_out_q, pc_out_d;
   logic [7:0]  sp_out_q, sp_out_d;
   logic [3:0]  src_q, src_d;

   logic        nnmi_q;
   logic        nmi_pend_q, nmi_pend_d;
   logic        rst_pend_q, rst_pend_d;

   logic [15:0] ret_q, ret_d;
   logic [7:0]  sp_q, sp_d;
   logic [7:0]  p_q, p_d;
   logic [15:0] vec_q, vec_d;
   logic [7:0]  vec_lo_q, vec_lo_d;

   logic        nmi_edge;
   logic        enc_valid;
   logic [3:0]  enc_src;
   logic        take_brk;
   logic        is_write;

   // Vector low-byte address for a source code
   function automatic logic [15:0] vector_for(input logic [3:0] src);
      logic [15:0] line_off;
      line_off = 16'(src) - 16'(SRC_IRQ0) - 16'd1;
      case (src)
         SRC_RST:           return RST_VEC;
         SRC_NMI:           return NMI_VEC;
         SRC_BRK, SRC_IRQ0: return IRQ_VEC;
         default:           return EXT_VEC_BASE + (line_off << 1);
      endcase
   endfunction

   assign nmi_edge = nnmi_q & ~nnmi;

   int_priority_enc #(
      .NUM_IRQ (NUM_IRQ)
   ) u_prio (
      .enable   (state_q == ST_IDLE && bus.boundary),
      .nmi_pend (nmi_pend_q),
      .brk_req  (bus.brk_req),
      .i_flag   (bus.i_flag),
      .nirq     (nirq),
      .valid    (enc_valid),
      .src_id   (enc_src)
   );

   always_ff @(posedge clock) begin
      if (nreset) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         addr_q     <= 16'h0000;
         data_out_q <= 8'h00;
         rw_q       <= 1'b1;
         pulse_q    <= 1'b0;
         pc_out_q   <= 16'h0000;
         sp_out_q   <= 8'h00;
         src_q      <= SRC_RST;
         nnmi_q     <= 1'b1;
         nmi_pend_q <= 1'b0;
         rst_pend_q <= 1'b1;
         ret_q      <= 16'h0000;
         sp_q       <= 8'h00;
         p_q        <= 8'h00;
         vec_q      <= 16'h0000;
         vec_lo_q   <= 8'h00;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         addr_q     <= addr_d;
         data_out_q <= data_out_d;
         rw_q       <= rw_d;
         pulse_q    <= pulse_d;
         pc_out_q   <= pc_out_d;
         sp_out_q   <= sp_out_d;
         src_q      <= src_d;
         nnmi_q     <= nnmi;
         nmi_pend_q <= nmi_pend_d;
         rst_pend_q <= rst_pend_d;
         ret_q      <= ret_d;
         sp_q       <= sp_d;
         p_q        <= p_d;
         vec_q      <= vec_d;
         vec_lo_q   <= vec_lo_d;
      end
   end

   // Next state plus the bus cycle for that next state, so addr/rw/data_out
   // come straight out of registers during each sequence cycle.
   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      ret_d      = ret_q;
      sp_d       = sp_q;
      p_d        = p_q;
      vec_d      = vec_q;
      vec_lo_d   = vec_lo_q;
      rst_pend_d = rst_pend_q;
      pulse_d    = 1'b0;
      pc_out_d   = pc_out_q;
      sp_out_d   = sp_out_q;
      take_brk   = 1'b0;

      // A fresh edge wins over the clear so an NMI arriving while the NMI
      // vector is being read is not lost.
      nmi_pend_d = nmi_pend_q;
      if (state_q == ST_C6 && src_q == SRC_NMI) begin
         nmi_pend_d = 1'b0;
      end
      if (nmi_edge) begin
         nmi_pend_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (rst_pend_q) begin
               state_d    = ST_C1;
               src_d      = SRC_RST;
               ret_d      = bus.pc_in;
               sp_d       = bus.sp_in;
               p_d        = bus.flags_in | P_UNUSED_BIT;
               vec_d      = RST_VEC;
               rst_pend_d = 1'b0;
            end else if (enc_valid) begin
               take_brk = (enc_src == SRC_BRK);
               state_d  = ST_C1;
               src_d    = enc_src;
               ret_d    = take_brk ? bus.pc_in + 16'd1 : bus.pc_in;
               sp_d     = bus.sp_in;
               p_d      = bus.flags_in | P_UNUSED_BIT | (take_brk ? P_BREAK_BIT : 8'h00);
               vec_d    = vector_for(enc_src);
            end
         end
         ST_C1: state_d = ST_C2;
         ST_C2: state_d = ST_C3;
         ST_C3: state_d = ST_C4;
         ST_C4: state_d = ST_C5;
         ST_C5: begin
            // NMI hijack: a BRK/IRQ still in flight is redirected to the
            // NMI vector; the P byte already pushed keeps its B bit.
            state_d = ST_C6;
            if (src_q >= SRC_BRK && (nmi_pend_q || nmi_edge)) begin
               src_d = SRC_NMI;
               vec_d = NMI_VEC;
            end
         end
         ST_C6: begin
            state_d  = ST_C7;
            vec_lo_d = bus.data_in;
         end
         ST_C7: begin
            state_d  = ST_IDLE;
            pulse_d  = 1'b1;
            pc_out_d = {bus.data_in, vec_lo_q};
            sp_out_d = sp_q - 8'd3;
         end
      endcase

      // Reset runs the same cycles but turns the three pushes into reads
      is_write   = (src_d != SRC_RST);
      busy_d     = (state_d != ST_IDLE);
      addr_d     = 16'h0000;
      rw_d       = 1'b1;
      data_out_d = 8'h00;
      case (state_d)
         ST_C1, ST_C2: addr_d = ret_d;
         ST_C3: begin
            addr_d     = stack_addr(sp_d);
            rw_d       = ~is_write;
            data_out_d = is_write ? ret_d[15:8] : 8'h00;
         end
         ST_C4: begin
            addr_d     = stack_addr(sp_d - 8'd1);
            rw_d       = ~is_write;
            data_out_d = is_write ? ret_d[7:0] : 8'h00;
         end
         ST_C5: begin
            addr_d     = stack_addr(sp_d - 8'd2);
            rw_d       = ~is_write;
            data_out_d = is_write ? p_d : 8'h00;
         end
         ST_C6:   addr_d = vec_d;
         ST_C7:   addr_d = vec_d + 16'd1;
         default: addr_d = 16'h0000;
      endcase
   end

   assign bus.busy     = busy_q;
   assign bus.addr     = addr_q;
   assign bus.data_out = data_out_q;
   assign bus.rw       = rw_q;
   assign bus.pc_load  = pulse_q;
   assign bus.sp_load  = pulse_q;
   assign bus.set_i    = pulse_q;
   assign bus.pc_out   = pc_out_q;
   assign bus.sp_out   = sp_out_q;
   assign bus.src_id   = src_q;

endmodule

// File: tb/tb_cpu_int_sequencer.sv
// tb_cpu_int_sequencer
// Self-checking bench for cpu_int_sequencer: directed reset/IRQ/BRK/NMI
// sequences, a table of arbitration vectors and randomized requests checked
// against a transaction-level model of the push/vector sequence.
module tb_cpu_int_sequencer;
   import cpu_int_sequencer_pkg::*;

   localparam int NIRQ = 3;

   logic            clock = 1'b0;
   logic            nreset;
   logic            nnmi;
   logic [NIRQ-1:0] nirq;

   logic [7:0] mem [0:65535];

   int n_vec  = 0;
   int n_miss = 0;
   bit nmi_owed = 1'b0;

   cpu_int_sequencer_if bus_if ();

   assign bus_if.data_in = mem[bus_if.addr];

   cpu_int_sequencer #(
      .NUM_IRQ (NIRQ)
   ) dut (
      .clock  (clock),
      .nreset (nreset),
      .nnmi   (nnmi),
      .nirq   (nirq),
      .bus    (bus_if)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit              brk;
      logic [NIRQ-1:0] irq_n;
      bit              iflag;
      logic [15:0]     pc;
      logic [7:0]      sp;
      logic [7:0]      fl;
      int              exp_src;
   } vec_t;

   vec_t tbl [9];

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_miss++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Vector low-byte address each source should use
   function automatic logic [15:0] model_vector(input int src);
      if (src == 0) return 16'hFFFC;
      if (src == 1) return 16'hFFFA;
      if (src == 2 || src == 3) return 16'hFFFE;
      return 16'hFFE0 + 16'(2 * (src - 4));
   endfunction

   // Which source an idle sequencer at a boundary should take; -1 for none
   function automatic int model_pick(input bit owed, input bit brk, input logic [NIRQ-1:0] irq_n, input bit iflag);
      if (owed) return 1;
      if (brk) return 2;
      if (!iflag) begin
         for (int k = 0; k < NIRQ; k++) begin
            if (!irq_n[k]) return 3 + k;
         end
      end
      return -1;
   endfunction

   task automatic apply_stimulus(input bit brk, input logic [NIRQ-1:0] irq_n, input bit iflag,
                                 input logic [15:0] pc, input logic [7:0] sp, input logic [7:0] fl);
      bus_if.brk_req  = brk;
      nirq            = irq_n;
      bus_if.i_flag   = iflag;
      bus_if.pc_in    = pc;
      bus_if.sp_in    = sp;
      bus_if.flags_in = fl;
      bus_if.boundary = 1'b1;
   endtask

   task automatic expect_no_accept(input string name);
      @(negedge clock);
      check_output({name, " busy"}, 32'(bus_if.busy), 32'd0);
      bus_if.boundary = 1'b0;
      bus_if.brk_req  = 1'b0;
      nirq            = '1;
      @(negedge clock);
      check_output({name, " busy2"}, 32'(bus_if.busy), 32'd0);
   endtask

   // Called at a negedge right after the accepting inputs were driven.
   // nmi_cycle: sequence cycle in which nnmi is pulsed low (outside 1..7: none).
   task automatic run_seq(input int src, input bit brk, input logic [15:0] pc, input logic [7:0] sp,
                          input logic [7:0] fl, input int nmi_cycle);
      logic [15:0] ret;
      logic [7:0]  p;
      logic [7:0]  s1, s2, s3;
      logic [15:0] vec;
      logic [15:0] vec_hi_addr;
      logic [15:0] exp_addr [1:8];
      logic [7:0]  exp_data [1:8];
      bit          exp_wr   [1:8];
      bit          hijack;
      int          fin;
      ret    = brk ? pc + 16'd1 : pc;
      p      = fl | 8'h20 | (brk ? 8'h10 : 8'h00);
      s1     = sp - 8'd1;
      s2     = sp - 8'd2;
      s3     = sp - 8'd3;
      hijack = (src >= 2) && (nmi_cycle >= 1) && (nmi_cycle <= 3);
      fin    = hijack ? 1 : src;
      vec    = model_vector(fin);
      vec_hi_addr = vec + 16'd1;
      for (int c = 1; c <= 7; c++) begin
         exp_wr[c]   = 1'b0;
         exp_data[c] = 8'h00;
      end
      exp_addr[1] = ret;
      exp_addr[2] = ret;
      exp_addr[3] = {8'h01, sp};
      exp_addr[4] = {8'h01, s1};
      exp_addr[5] = {8'h01, s2};
      exp_addr[6] = vec;
      exp_addr[7] = vec_hi_addr;
      if (src != 0) begin
         exp_wr[3] = 1'b1; exp_data[3] = ret[15:8];
         exp_wr[4] = 1'b1; exp_data[4] = ret[7:0];
         exp_wr[5] = 1'b1; exp_data[5] = p;
      end

      @(negedge clock);
      bus_if.boundary = 1'b0;
      bus_if.brk_req  = 1'b0;
      nirq            = '1;
      bus_if.pc_in    = 16'($urandom);
      bus_if.sp_in    = 8'($urandom);
      bus_if.flags_in = 8'($urandom);
      for (int c = 1; c <= 7; c++) begin
         check_output($sformatf("src%0d c%0d busy", src, c), 32'(bus_if.busy), 32'd1);
         check_output($sformatf("src%0d c%0d addr", src, c), 32'(bus_if.addr), 32'(exp_addr[c]));
         check_output($sformatf("src%0d c%0d rw", src, c), 32'(bus_if.rw), 32'(!exp_wr[c]));
         if (exp_wr[c]) begin
            check_output($sformatf("src%0d c%0d data", src, c), 32'(bus_if.data_out), 32'(exp_data[c]));
         end
         if (c == nmi_cycle) nnmi = 1'b0;
         else if (c == nmi_cycle + 1) nnmi = 1'b1;
         @(negedge clock);
      end
      if (nmi_cycle == 7) nnmi = 1'b1;
      check_output($sformatf("src%0d pc_load", src), 32'(bus_if.pc_load), 32'd1);
      check_output($sformatf("src%0d sp_load", src), 32'(bus_if.sp_load), 32'd1);
      check_output($sformatf("src%0d set_i", src), 32'(bus_if.set_i), 32'd1);
      check_output($sformatf("src%0d end busy", src), 32'(bus_if.busy), 32'd0);
      check_output($sformatf("src%0d pc_out", src), 32'(bus_if.pc_out), 32'({mem[vec_hi_addr], mem[vec]}));
      check_output($sformatf("src%0d sp_out", src), 32'(bus_if.sp_out), 32'(s3));
      check_output($sformatf("src%0d src_id", src), 32'(bus_if.src_id), 32'(fin));
      if (fin == 1) nmi_owed = 1'b0;
      if (nmi_cycle == 7 || (src == 0 && nmi_cycle >= 1 && nmi_cycle <= 3)) nmi_owed = 1'b1;
      @(negedge clock);
      check_output($sformatf("src%0d pulse width", src), 32'(bus_if.pc_load), 32'd0);
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
      mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
      mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'hC0;
      mem[16'hFFE0] = 8'h5A; mem[16'hFFE1] = 8'hA0;
      mem[16'hFFE2] = 8'hA5; mem[16'hFFE3] = 8'hB0;

      tbl[0] = '{1'b0, 3'b111, 1'b0, 16'h1000, 8'hFF, 8'h00, -1};
      tbl[1] = '{1'b0, 3'b110, 1'b0, 16'h1100, 8'hF0, 8'h02, 3};
      tbl[2] = '{1'b0, 3'b101, 1'b0, 16'h1200, 8'hE0, 8'h40, 4};
      tbl[3] = '{1'b0, 3'b011, 1'b0, 16'h1300, 8'h02, 8'h80, 5};
      tbl[4] = '{1'b0, 3'b100, 1'b0, 16'h1400, 8'h00, 8'hC3, 3};
      tbl[5] = '{1'b0, 3'b000, 1'b1, 16'h1500, 8'h70, 8'h04, -1};
      tbl[6] = '{1'b1, 3'b000, 1'b1, 16'h16FF, 8'h71, 8'h04, 2};
      tbl[7] = '{1'b0, 3'b001, 1'b0, 16'h1700, 8'h72, 8'h00, 4};
      tbl[8] = '{1'b0, 3'b101, 1'b1, 16'h1800, 8'h73, 8'h00, -1};

      nreset          = 1'b1;
      nnmi            = 1'b1;
      nirq            = '1;
      bus_if.boundary = 1'b0;
      bus_if.brk_req  = 1'b0;
      bus_if.i_flag   = 1'b0;
      bus_if.pc_in    = 16'h4321;
      bus_if.sp_in    = 8'hFD;
      bus_if.flags_in = 8'h00;
      repeat (3) @(negedge clock);

      check_output("reset busy", 32'(bus_if.busy), 32'd0);
      check_output("reset rw", 32'(bus_if.rw), 32'd1);
      check_output("reset addr", 32'(bus_if.addr), 32'd0);
      check_output("reset data_out", 32'(bus_if.data_out), 32'd0);
      check_output("reset pc_load", 32'(bus_if.pc_load), 32'd0);
      check_output("reset sp_load", 32'(bus_if.sp_load), 32'd0);
      check_output("reset set_i", 32'(bus_if.set_i), 32'd0);
      check_output("reset pc_out", 32'(bus_if.pc_out), 32'd0);
      check_output("reset sp_out", 32'(bus_if.sp_out), 32'd0);
      check_output("reset src_id", 32'(bus_if.src_id), 32'd0);

      // Reset sequence starts on the first edge after release
      nreset = 1'b0;
      run_seq(0, 1'b0, 16'h4321, 8'hFD, 8'h00, -5);

      apply_stimulus(1'b0, 3'b111, 1'b0, 16'h0000, 8'hFF, 8'h00);
      expect_no_accept("idle no request");

      // IRQ0 push and vector
      apply_stimulus(1'b0, 3'b110, 1'b0, 16'h1234, 8'hFF, 8'h01);
      run_seq(3, 1'b0, 16'h1234, 8'hFF, 8'h01, -5);

      // BRK beats a pending IRQ1
      apply_stimulus(1'b1, 3'b101, 1'b0, 16'h2000, 8'hF0, 8'h00);
      run_seq(2, 1'b1, 16'h2000, 8'hF0, 8'h00, -5);

      // NMI edge during C3 hijacks a BRK and is consumed by it
      apply_stimulus(1'b1, 3'b111, 1'b0, 16'h3000, 8'h80, 8'h00);
      run_seq(2, 1'b1, 16'h3000, 8'h80, 8'h00, 3);
      apply_stimulus(1'b0, 3'b111, 1'b0, 16'h3100, 8'h80, 8'h00);
      expect_no_accept("after hijack");

      // NMI held low across two boundaries triggers once; stack wraps
      nnmi = 1'b0;
      @(negedge clock);
      apply_stimulus(1'b0, 3'b111, 1'b0, 16'h5555, 8'h01, 8'h80);
      run_seq(1, 1'b0, 16'h5555, 8'h01, 8'h80, -5);
      apply_stimulus(1'b0, 3'b111, 1'b0, 16'h5600, 8'h01, 8'h00);
      expect_no_accept("nmi held low");
      nnmi = 1'b1;
      @(negedge clock);

      for (int i = 0; i < 9; i++) begin
         apply_stimulus(tbl[i].brk, tbl[i].irq_n, tbl[i].iflag, tbl[i].pc, tbl[i].sp, tbl[i].fl);
         if (tbl[i].exp_src < 0) begin
            expect_no_accept($sformatf("tbl%0d", i));
         end else begin
            run_seq(tbl[i].exp_src, tbl[i].exp_src == 2, tbl[i].pc, tbl[i].sp, tbl[i].fl, -5);
         end
      end

      // Reset asserted during C4 aborts, then the reset sequence runs
      apply_stimulus(1'b0, 3'b110, 1'b0, 16'h6000, 8'h40, 8'h00);
      @(negedge clock);
      bus_if.boundary = 1'b0;
      nirq            = '1;
      check_output("abort c1 busy", 32'(bus_if.busy), 32'd1);
      repeat (3) @(negedge clock);
      check_output("abort c4 addr", 32'(bus_if.addr), 32'h013F);
      check_output("abort c4 rw", 32'(bus_if.rw), 32'd0);
      nreset = 1'b1;
      @(negedge clock);
      check_output("abort busy", 32'(bus_if.busy), 32'd0);
      check_output("abort addr", 32'(bus_if.addr), 32'd0);
      check_output("abort rw", 32'(bus_if.rw), 32'd1);
      check_output("abort pc_load", 32'(bus_if.pc_load), 32'd0);
      nreset          = 1'b0;
      nmi_owed        = 1'b0;
      bus_if.pc_in    = 16'h7000;
      bus_if.sp_in    = 8'h10;
      bus_if.flags_in = 8'h00;
      run_seq(0, 1'b0, 16'h7000, 8'h10, 8'h00, -5);

      // Randomized requests against the model
      for (int it = 0; it < 40; it++) begin
         bit              r_brk;
         logic [NIRQ-1:0] r_irq;
         bit              r_if;
         logic [15:0]     r_pc;
         logic [7:0]      r_sp;
         logic [7:0]      r_fl;
         int              exp;
         int              nc;
         r_brk = ($urandom_range(0, 3) == 0);
         r_irq = NIRQ'($urandom);
         r_if  = 1'($urandom);
         r_pc  = 16'($urandom_range(0, 16'hEFFF));
         r_sp  = 8'($urandom);
         r_fl  = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            nnmi = 1'b0;
            @(negedge clock);
            nnmi     = 1'b1;
            nmi_owed = 1'b1;
         end
         apply_stimulus(r_brk, r_irq, r_if, r_pc, r_sp, r_fl);
         exp = model_pick(nmi_owed, r_brk, r_irq, r_if);
         if (exp < 0) begin
            expect_no_accept($sformatf("rnd%0d", it));
         end else begin
            if (exp >= 2 && $urandom_range(0, 2) == 0) nc = int'($urandom_range(1, 3));
            else if ($urandom_range(0, 3) == 0) nc = 7;
            else nc = -5;
            run_seq(exp, exp == 2, r_pc, r_sp, r_fl, nc);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
